// File: rtl/rv_ram_reader_if.sv
// Request/response handshake bundle for rv_ram_reader.
// The requester uses the master modport, the reader uses the slave modport.
interface rv_ram_reader_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 8
);
    logic             req_valid;
    logic [ADDRW-1:0] req_addr;
    logic             req_ready;
    logic             rsp_valid;
    logic [DATAW-1:0] rsp_data;
    logic             rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rv_ram_reader.sv
// Read-side initiator for a dual-port RAM: issues reads, queues returned data in a
// credit-protected response FIFO. Optional write-snoop bypass: RV_RAM_RD_BYPASS_EN.
module rv_ram_reader #(
    parameter int DATAW     = 32,
    parameter int ADDRW     = 8,
    parameter int RAM_LAT   = 1,
    parameter int RSP_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    rv_ram_reader_if.slave   bus,
    output logic [ADDRW-1:0] ram_raddr,
    input  logic [DATAW-1:0] ram_rdata,
    input  logic             ram_wren,
    input  logic [ADDRW-1:0] ram_waddr,
    input  logic [DATAW-1:0] ram_wdata
);

    localparam int CNTW = $clog2(RSP_DEPTH + 2) + 1;
    localparam int PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic             fire;
    logic             pop;
    logic             push;
    logic [DATAW-1:0] push_data;
    logic             hit;
    logic             ready_en;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  inflight;
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [DATAW-1:0] fifo_mem [RSP_DEPTH];

    assign fire      = bus.req_valid & bus.req_ready;
    assign pop       = bus.rsp_valid & bus.rsp_ready;
    assign ram_raddr = bus.req_addr;

    // Credits count every outstanding read so a push can never land on a full FIFO;
    // only registered terms feed req_ready.
    assign bus.req_ready = ready_en && ((count + inflight) < CNTW'(RSP_DEPTH));
    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_data  = fifo_mem[rd_ptr];

`ifdef RV_RAM_RD_BYPASS_EN
    assign hit = ram_wren && (ram_waddr == bus.req_addr);
`else
    logic unused_snoop;
    assign hit          = 1'b0;
    assign unused_snoop = ^{ram_wren, ram_waddr};
`endif

    generate
        if (RAM_LAT == 0) begin : g_lat0
            assign push      = fire;
            assign push_data = hit ? ram_wdata : ram_rdata;
            assign inflight  = '0;
        end else begin : g_lat1
            logic             pipe_vld;
            logic             pipe_hit;
            logic [DATAW-1:0] pipe_wdata;

            // The RAM registers the address at the issue edge; the matching
            // data (or the snooped write data) is pushed one edge later.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_vld   <= 1'b0;
                    pipe_hit   <= 1'b0;
                    pipe_wdata <= '0;
                end else begin
                    pipe_vld   <= fire;
                    pipe_hit   <= fire & hit;
                    pipe_wdata <= ram_wdata;
                end
            end

            assign push      = pipe_vld;
            assign push_data = pipe_hit ? pipe_wdata : ram_rdata;
            assign inflight  = CNTW'(pipe_vld);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PTRW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTRW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_ram_reader.sv
// Bench for rv_ram_reader: a zero-latency and a one-latency instance share one RAM
// and identical stimulus; each is compared every cycle against an outstanding-read queue.
module tb_rv_ram_reader;

    localparam int DATAW = 32;
    localparam int ADDRW = 8;
    localparam int DEPTH = 3;

    typedef struct {
        logic [DATAW-1:0] data;
        int               avail;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic             wr_en = 1'b0;
    logic [ADDRW-1:0] wr_addr = '0;
    logic [DATAW-1:0] wr_data = '0;
    logic             preload_en = 1'b0;
    logic [DATAW-1:0] ram_mem [256];
    logic [ADDRW-1:0] raddr0, raddr1;
    logic [DATAW-1:0] rdata0, rdata1;

    logic             cur_valid = 1'b0;
    logic [ADDRW-1:0] cur_addr = '0;
    logic             cur_rready = 1'b0;

    rsp_t q[2][$];
    int   lat[2] = '{0, 1};
    int   cyc = 0;
    bit   ready_ok = 1'b0;
    int   passed = 0;
    int   total = 0;

    rv_ram_reader_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus0 ();
    rv_ram_reader_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus1 ();

    rv_ram_reader #(.DATAW(DATAW), .ADDRW(ADDRW), .RAM_LAT(0), .RSP_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .ram_raddr(raddr0), .ram_rdata(rdata0),
        .ram_wren(wr_en), .ram_waddr(wr_addr), .ram_wdata(wr_data)
    );

    rv_ram_reader #(.DATAW(DATAW), .ADDRW(ADDRW), .RAM_LAT(1), .RSP_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .ram_raddr(raddr1), .ram_rdata(rdata1),
        .ram_wren(wr_en), .ram_waddr(wr_addr), .ram_wdata(wr_data)
    );

    // Shared RAM: async read port for the zero-latency reader, registered
    // read-before-write port for the other.
    always @(posedge clk) begin
        if (preload_en) begin
            for (int a = 0; a < 256; a++) ram_mem[a] <= DATAW'(a * 3);
        end else if (wr_en) begin
            ram_mem[wr_addr] <= wr_data;
        end
        rdata1 <= ram_mem[raddr1];
    end
    assign rdata0 = ram_mem[raddr0];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        else passed++;
    endtask

    task automatic applyStimulus(input logic v, input logic [ADDRW-1:0] a, input logic rr,
                                 input logic we, input logic [ADDRW-1:0] wa, input logic [DATAW-1:0] wd);
        cur_valid  = v;
        cur_addr   = a;
        cur_rready = rr;
        bus0.req_valid = v;  bus1.req_valid = v;
        bus0.req_addr  = a;  bus1.req_addr  = a;
        bus0.rsp_ready = rr; bus1.rsp_ready = rr;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
    endtask

    task automatic checkAll();
        logic             dv, dr;
        logic [DATAW-1:0] dd;
        bit               vis, rdy;
        for (int i = 0; i < 2; i++) begin
            dv = (i == 0) ? bus0.rsp_valid : bus1.rsp_valid;
            dr = (i == 0) ? bus0.req_ready : bus1.req_ready;
            dd = (i == 0) ? bus0.rsp_data  : bus1.rsp_data;
            vis = (q[i].size() > 0) && (q[i][0].avail <= cyc);
            rdy = ready_ok && (q[i].size() < DEPTH);
            checkOutput($sformatf("rsp_valid_lat%0d", lat[i]), 64'(dv), 64'(vis));
            checkOutput($sformatf("req_ready_lat%0d", lat[i]), 64'(dr), 64'(rdy));
            if (vis) checkOutput($sformatf("rsp_data_lat%0d", lat[i]), 64'(dd), 64'(q[i][0].data));
        end
    endtask

    // One clock: settle the model on the pre-edge view, clock, then compare.
    task automatic cycle();
        logic [DATAW-1:0] exp_data;
        rsp_t             e;
        bit               vis, rdy;
        for (int i = 0; i < 2; i++) begin
            vis = (q[i].size() > 0) && (q[i][0].avail <= cyc);
            rdy = ready_ok && (q[i].size() < DEPTH);
            if (vis && cur_rready) void'(q[i].pop_front());
            if (cur_valid && rdy) begin
                exp_data = ram_mem[cur_addr];
`ifdef RV_RAM_RD_BYPASS_EN
                if (wr_en && (wr_addr == cur_addr)) exp_data = wr_data;
`endif
                e.data  = exp_data;
                e.avail = cyc + 1 + lat[i];
                q[i].push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        if (reset_n) ready_ok = 1'b1;
        @(negedge clk);
        checkAll();
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valid0", 64'(bus0.rsp_valid), 64'd0);
        checkOutput("rst_rsp_valid1", 64'(bus1.rsp_valid), 64'd0);
        checkOutput("rst_req_ready0", 64'(bus0.req_ready), 64'd0);
        checkOutput("rst_req_ready1", 64'(bus1.req_ready), 64'd0);
        checkOutput("rst_rsp_data0",  64'(bus0.rsp_data),  64'd0);
        checkOutput("rst_rsp_data1",  64'(bus1.rsp_data),  64'd0);
        q[0].delete();
        q[1].delete();
        ready_ok = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, '0, 1, 0, '0, '0);
            cycle();
        end
    endtask

    initial begin
        applyStimulus(0, '0, 0, 0, '0, '0);
        preload_en = 1'b1;
        applyReset();
        preload_en = 1'b0;
        idle(2);

        $display("[TB] reset mid-burst with queued responses");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, ADDRW'(10 + k), 0, 0, '0, '0);
            cycle();
        end
        applyStimulus(0, '0, 0, 0, '0, '0);
        cycle();
        applyReset();
        idle(5);

        $display("[TB] back-to-back burst");
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1, ADDRW'(a), 1, 0, '0, '0);
            cycle();
        end
        idle(5);

        $display("[TB] credit exhaustion under backpressure");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, ADDRW'(20 + k), 0, 0, '0, '0);
            cycle();
        end
        idle(8);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, ADDRW'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                          ADDRW'($urandom_range(0, 15)), DATAW'($urandom));
            cycle();
        end
        idle(8);

        $display("[TB] read during write");
        applyStimulus(0, '0, 1, 1, 8'd5, 32'h1111);
        cycle();
        applyStimulus(1, 8'd5, 1, 1, 8'd5, 32'hDEAD);
        cycle();
        idle(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
